ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the ALU result, store-data and branch-target fields.
REQ-002 SHALL have parameter REG_W, default 5, width of the register-specifier fields.
REQ-003 SHALL have parameter CTRL_W, default 8, width of the opaque control bundle (MemtoReg, MemRead, MemWrite, RegWrite, ...).
REQ-004 SHALL have parameter CNT_W, default 16, width of the squash counter.
REQ-005 SHALL have these ports, one per line:
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  control bundle
- in_alu_out  in  DATA_W  ALU result
- in_alu_b  in  DATA_W  store data
- in_pc_branch  in  DATA_W  branch/jump target
- in_rt, in_rd  in  REG_W  register specifiers
- in_is_r  in  1  R-type: destination is rd, else rt
- in_branch, in_taken, in_jump  in  1  branch instruction, condition true, unconditional jump
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl, out_alu_out, out_alu_b, out_dest  out  as input widths  head-entry fields
- pc_src  out  1  one-cycle redirect pulse
- redirect_pc  out  DATA_W  target valid while pc_src=1
- squash_cnt  out  CNT_W  wrong-path beats dropped

Function
REQ-006 SHALL hold up to two entries in a FIFO-ordered skid buffer; in_ready SHALL be 1 iff fewer than two entries are held and SHALL be a registered signal with no combinational path from out_ready.
REQ-007 SHALL accept a beat when in_valid and in_ready are both 1; pop the head when out_valid and out_ready are both 1.
REQ-008 SHALL store out_dest = in_is_r ? in_rd : in_rt at acceptance.
REQ-009 SHALL have a latency of one cycle: a beat accepted into an empty buffer SHALL drive out_valid=1 on the next cycle.
REQ-010 SHALL, with one entry held, leave the count at one on a simultaneous push and pop and present the new beat next cycle.
REQ-011 SHALL, when an accepted, non-squashed beat has (in_branch and in_taken) or in_jump, drive pc_src=1 for exactly the following cycle, with redirect_pc equal to that beat's in_pc_branch, and set the shadow flag.
REQ-012 SHALL, while the shadow flag is set, drop the next accepted beat: the beat is not stored, causes no redirect, and increments squash_cnt; the shadow flag SHALL then clear.
REQ-013 SHALL saturate squash_cnt at all-ones.
REQ-014 SHALL give flush highest priority: on that edge, clear the count and the shadow flag, discard any incoming beat without counting it, and drive pc_src=0 on the next cycle.
REQ-015 SHALL keep out_* fields stable while out_valid=1 and out_ready=0.

Reset
REQ-016 SHALL, on rst_n=0, clear both entries and the shadow flag, and drive out_valid=0, pc_src=0, redirect_pc=0, squash_cnt=0, all out_* data fields 0 and in_ready=1.
REQ-017 SHALL, on reset asserted mid-redirect or mid-shadow, suppress any pending pc_src pulse and squash.

Configuration
REQ-018 SHALL, with macro EX_MEM_STAGE_FWD_EN defined, add outputs fwd_valid (1), fwd_dest (REG_W) and fwd_data (DATA_W). These SHALL reflect the head entry: fwd_valid = out_valid and RegWrite bit 0 of out_ctrl, fwd_dest = out_dest, fwd_data = out_alu_out.
REQ-019 SHALL, without EX_MEM_STAGE_FWD_EN, omit these ports and their logic entirely.

Structure
REQ-020 SHALL take default widths and the CTRL bit-position constants (RegWrite=0, MemtoReg=1, MemRead=2, MemWrite=3) from shared package cpu_pipe_pkg, which also holds the entry struct type.
REQ-021 SHALL instantiate one sub-module, skid_buf2, as a generic two-entry buffer; the redirect, shadow and counter logic SHALL stay in ex_mem_stage.

Verification
REQ-022 The bench SHALL cover: reset, then a beat with in_is_r=1, rd=7, rt=3, alu_out=0x10 -> next cycle out_valid=1, out_dest=7, out_alu_out=0x10.
REQ-023 The bench SHALL cover: out_ready=0 and three beats offered -> in_ready=0 after two accepts, then release -> beats emerge in order, none lost.
REQ-024 The bench SHALL cover: a taken branch with pc_branch=0x40 followed by a beat with alu_out=0x99 -> pc_src=1 for one cycle, redirect_pc=0x40, 0x99 never appears, squash_cnt=1.
REQ-025 The bench SHALL cover: a jump, then flush in the next cycle with a beat offered -> buffer empty, shadow cleared, squash_cnt unchanged, and the following beat accepted normally.
REQ-026 The bench SHALL cover: squash_cnt preloaded near saturation via 0xFFFF squashes -> stays 0xFFFF on further squashes.
REQ-027 The bench SHALL cover: rst_n asserted on the cycle pc_src would fire -> pc_src=0, out_valid=0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default field widths, control-bundle bit positions
// and the EX/MEM entry layout used by the pipeline stages.
package cpu_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

    // Field order matches the packed vector carried through the skid buffer.
    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] alu_out;
        logic [DATA_W_DEF-1:0] alu_b;
        logic [REG_W_DEF-1:0]  dest;
    } ex_mem_entry_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry FIFO-ordered skid buffer with a registered ready, so the
// upstream handshake never depends combinationally on the downstream ready.
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q;
    logic         push, pop;

    assign push    = push_i && ready_q;
    assign pop     = (cnt_q != 2'd0) && pop_i;
    assign valid_o = (cnt_q != 2'd0);
    assign ready_o = ready_q;
    assign data_o  = mem_q[0];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
            if (!clr_i) begin
                // Head slot is rewritten only when it is empty or being popped,
                // so a stalled head stays stable.
                if (pop) begin
                    if (cnt_q == 2'd2) begin
                        mem_q[0] <= mem_q[1];
                    end else if (push) begin
                        mem_q[0] <= data_i;
                    end
                end else if (push) begin
                    if (cnt_q == 2'd0) begin
                        mem_q[0] <= data_i;
                    end else begin
                        mem_q[1] <= data_i;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer plus branch/jump redirect, one-beat
// wrong-path squash and a saturating squash counter. Define EX_MEM_STAGE_FWD_EN to add forwarding outputs.
module ex_mem_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_alu_b,
    input  logic [DATA_W-1:0] in_pc_branch,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_is_r,
    input  logic              in_branch,
    input  logic              in_taken,
    input  logic              in_jump,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_alu_b,
    output logic [REG_W-1:0]  out_dest,
    output logic              pc_src,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  squash_cnt
`ifdef EX_MEM_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int ENTRY_W = CTRL_W + 2 * DATA_W + REG_W;

    logic               accept, fire, squash, push;
    logic [REG_W-1:0]   dest;
    logic [ENTRY_W-1:0] entry_in, entry_out;

    logic              shadow_q, shadow_d;
    logic              pc_src_q, pc_src_d;
    logic [DATA_W-1:0] redirect_q, redirect_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign accept = in_valid && in_ready;
    assign squash = accept && shadow_q && !flush;
    assign fire   = accept && !shadow_q && !flush && ((in_branch && in_taken) || in_jump);
    // Squashed or flushed beats are still accepted upstream, just never stored.
    assign push   = in_valid && !shadow_q && !flush;

    assign dest     = in_is_r ? in_rd : in_rt;
    assign entry_in = {in_ctrl, in_alu_out, in_alu_b, dest};

    skid_buf2 #(
        .W(ENTRY_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .push_i (push),
        .data_i (entry_in),
        .ready_o(in_ready),
        .pop_i  (out_ready),
        .valid_o(out_valid),
        .data_o (entry_out)
    );

    assign {out_ctrl, out_alu_out, out_alu_b, out_dest} = entry_out;

    always_comb begin
        shadow_d   = shadow_q;
        pc_src_d   = fire;
        redirect_d = fire ? in_pc_branch : redirect_q;
        cnt_d      = cnt_q;
        if (flush) begin
            shadow_d = 1'b0;
        end else if (accept) begin
            // A squashed beat can never fire, so this also clears the shadow.
            shadow_d = fire;
        end
        if (squash && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= 1'b0;
            pc_src_q   <= 1'b0;
            redirect_q <= '0;
            cnt_q      <= '0;
        end else begin
            shadow_q   <= shadow_d;
            pc_src_q   <= pc_src_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_src      = pc_src_q;
    assign redirect_pc = redirect_q;
    assign squash_cnt  = cnt_q;

`ifdef EX_MEM_STAGE_FWD_EN
    assign fwd_valid = out_valid && out_ctrl[CTRL_REGWRITE];
    assign fwd_dest  = out_dest;
    assign fwd_data  = out_alu_out;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: handshake, ordering, redirect/squash, flush,
// counter saturation (counter narrowed to 8 bits to keep the run short) and reset.
module tb_ex_mem_stage;
    import cpu_pipe_pkg::*;

    localparam int CNT_W = 8;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_alu_out;
    logic [31:0] in_alu_b;
    logic [31:0] in_pc_branch;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_is_r;
    logic        in_branch;
    logic        in_taken;
    logic        in_jump;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_alu_out;
    logic [31:0] out_alu_b;
    logic [4:0]  out_dest;
    logic        pc_src;
    logic [31:0] redirect_pc;
    logic [CNT_W-1:0] squash_cnt;
`ifdef EX_MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ex_mem_entry_t exp_e;

    ex_mem_stage #(
        .DATA_W(32),
        .REG_W (5),
        .CTRL_W(8),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_alu_out  (in_alu_out),
        .in_alu_b    (in_alu_b),
        .in_pc_branch(in_pc_branch),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_is_r     (in_is_r),
        .in_branch   (in_branch),
        .in_taken    (in_taken),
        .in_jump     (in_jump),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_alu_out (out_alu_out),
        .out_alu_b   (out_alu_b),
        .out_dest    (out_dest),
        .pc_src      (pc_src),
        .redirect_pc (redirect_pc),
        .squash_cnt  (squash_cnt)
`ifdef EX_MEM_STAGE_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] ctrl, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] rt, input logic [4:0] rd, input logic is_r,
                        input logic br, input logic tk, input logic jp);
        in_valid     = 1'b1;
        in_ctrl      = ctrl;
        in_alu_out   = alu;
        in_alu_b     = alu ^ 32'hFFFF_0000;
        in_pc_branch = pc;
        in_rt        = rt;
        in_rd        = rd;
        in_is_r      = is_r;
        in_branch    = br;
        in_taken     = tk;
        in_jump      = jp;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_branch = 1'b0;
        in_taken  = 1'b0;
        in_jump   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0; in_ctrl = '0; in_alu_out = '0; in_alu_b = '0; in_pc_branch = '0;
        in_rt = '0; in_rd = '0; in_is_r = 1'b0; in_branch = 1'b0; in_taken = 1'b0; in_jump = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_squash_cnt", 32'(squash_cnt), 32'd0);
        chk("rst_out_alu_out", out_alu_out, 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        #2 rst_n = 1'b1;
        $display("step reset done");

        // R-type beat: dest is rd, one-cycle latency
        tick();
        beat(8'h01, 32'h10, 32'h0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        exp_e = '{ctrl: 8'h01, alu_out: 32'h10, alu_b: 32'hFFFF_0010, dest: 5'd7};
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_dest", 32'(out_dest), 32'(exp_e.dest));
        chk("t1_out_alu_out", out_alu_out, exp_e.alu_out);
        chk("t1_out_alu_b", out_alu_b, exp_e.alu_b);
        chk("t1_out_ctrl", 32'(out_ctrl), 32'(exp_e.ctrl));
`ifdef EX_MEM_STAGE_FWD_EN
        chk("t1_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("t1_fwd_dest", 32'(fwd_dest), 32'd7);
`endif
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);
        $display("step single beat done");

        // Backpressure: three beats, only two fit
        out_ready = 1'b0;
        beat(8'h00, 32'h21, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2_ready_after_1", 32'(in_ready), 32'd1);
        beat(8'h00, 32'h22, 32'h0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2_ready_after_2", 32'(in_ready), 32'd0);
        chk("t2_head_a", out_alu_out, 32'h21);
        beat(8'h00, 32'h23, 32'h0, 5'd9, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2_still_full", 32'(in_ready), 32'd0);
        chk("t2_head_stable", out_alu_out, 32'h21);
        out_ready = 1'b1;
        tick();
        chk("t2_head_b", out_alu_out, 32'h22);
        chk("t2_ready_again", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("t2_head_c", out_alu_out, 32'h23);
        chk("t2_dest_rt", 32'(out_dest), 32'd9);
        tick();
        chk("t2_drained", 32'(out_valid), 32'd0);
        $display("step backpressure done");

        // Not-taken branch, then taken branch followed by a wrong-path beat
        beat(8'h00, 32'h31, 32'h30, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t3_nt_pc_src", 32'(pc_src), 32'd0);
        chk("t3_nt_head", out_alu_out, 32'h31);
        beat(8'h00, 32'h55, 32'h40, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t3_pc_src", 32'(pc_src), 32'd1);
        chk("t3_redirect_pc", redirect_pc, 32'h40);
        chk("t3_head_branch", out_alu_out, 32'h55);
        beat(8'h00, 32'h99, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t3_pc_src_pulse", 32'(pc_src), 32'd0);
        chk("t3_squashed", 32'(out_valid), 32'd0);
        chk("t3_squash_cnt", 32'(squash_cnt), 32'd1);
        tick();
        chk("t3_no_099", 32'(out_valid), 32'd0);
        $display("step branch squash done");

        // Jump, then flush with a beat offered
        beat(8'h00, 32'h81, 32'h80, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t4_pc_src", 32'(pc_src), 32'd1);
        chk("t4_redirect_pc", redirect_pc, 32'h80);
        beat(8'h00, 32'hAA, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_empty", 32'(out_valid), 32'd0);
        chk("t4_flush_pc_src", 32'(pc_src), 32'd0);
        chk("t4_flush_cnt", 32'(squash_cnt), 32'd1);
        chk("t4_flush_ready", 32'(in_ready), 32'd1);
        beat(8'h00, 32'hBB, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t4_after_valid", 32'(out_valid), 32'd1);
        chk("t4_after_head", out_alu_out, 32'hBB);
        chk("t4_after_cnt", 32'(squash_cnt), 32'd1);
        tick();
        $display("step flush done");

        // Drive the counter up to saturation
        for (int i = 0; i < 253; i++) begin
            beat(8'h00, 32'h1, 32'h100, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            beat(8'h00, 32'h2, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("t5_near_sat", 32'(squash_cnt), 32'hFE);
        for (int i = 0; i < 3; i++) begin
            beat(8'h00, 32'h1, 32'h100, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            beat(8'h00, 32'h2, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            idle();
            chk($sformatf("t5_sat_%0d", i), 32'(squash_cnt), 32'hFF);
        end
        tick();
        $display("step saturation done");

        // Reset while the redirect pulse is live and the shadow is armed
        beat(8'h00, 32'hC1, 32'hC0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("t6_pc_src_before", 32'(pc_src), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pc_src", 32'(pc_src), 32'd0);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_cnt", 32'(squash_cnt), 32'd0);
        tick();
        chk("t6_rst_hold_pc_src", 32'(pc_src), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        beat(8'h00, 32'hDD, 32'h0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_post_valid", 32'(out_valid), 32'd1);
        chk("t6_post_head", out_alu_out, 32'hDD);
        chk("t6_post_cnt", 32'(squash_cnt), 32'd0);
        $display("step reset mid-redirect done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
